datamem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (combinational read, clocked write) between the CPU datapath and a debug/loader port. It sits between the ALU-result/RD2 temp registers and the data memory, replacing the direct CPU connection. It uses round-robin with a bounded burst, so neither requester starves. Read data is returned through a registered response, matching the datapath's one-cycle temp-register style.

---
 rtl/datamem_arbiter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_datamem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// ============================================================================
// datamem_arbiter
// ----------------------------------------------------------------------------
// Shares one data memory (combinational read, clocked write) between the CPU
// datapath and a debug/loader port.
//
// Arbitration is round-robin with a bounded burst. While both ports request,
// the current owner keeps the memory for at most MAX_BURST consecutive
// cycles, then the other port takes over. A tie from idle goes to the port
// that did not win last time.
//
// The grant is combinational, so an uncontended request is served in the
// same cycle. Read data is registered and returned one cycle after the grant
// with a single-cycle rvalid. This matches the temp-register timing of the
// datapath.
//
// Ports
//   clk, rst                 : clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata    : CPU request; held stable until cpu_gnt
//   cpu_gnt                  : access performed this cycle (combinational)
//   cpu_rvalid/cpu_rdata     : registered read response, one cycle after gnt
//   dbg_*                    : same set for the debug/loader port
//   mem_A/mem_WD/mem_WE      : memory address, write data, write enable
//   mem_RD                   : memory combinational read data
// ============================================================================
module datamem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,

    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    output logic          mem_WE,
    input  logic [DW-1:0] mem_RD
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    typedef enum logic {
        LAST_CPU = 1'b0,
        LAST_DBG = 1'b1
    } last_t;

    owner_t        owner_r,     owner_nx_s;
    last_t         last_r,      last_nx_s;
    logic [CW-1:0] burst_cnt_r, burst_cnt_nx_s;

    logic          gnt_cpu_s;
    logic          gnt_dbg_s;

    logic          cpu_rvalid_r;
    logic [DW-1:0] cpu_rdata_r;
    logic          dbg_rvalid_r;
    logic [DW-1:0] dbg_rdata_r;

    // Grant decision: combinational from the requests and the arbitration state.
    // Grants are forced low while reset is held, so no write can slip through.
    always_comb begin
        gnt_cpu_s = 1'b0;
        gnt_dbg_s = 1'b0;
        if (!rst) begin
            gnt_cpu_s = 1'b0;
            gnt_dbg_s = 1'b0;
        end else if (cpu_req && !dbg_req) begin
            gnt_cpu_s = 1'b1;
        end else if (dbg_req && !cpu_req) begin
            gnt_dbg_s = 1'b1;
        end else if (cpu_req && dbg_req) begin
            case (owner_r)
                OWN_CPU: begin
                    // The owner keeps the bus until its burst allowance is used up.
                    if (burst_cnt_r < MAX_CNT) begin
                        gnt_cpu_s = 1'b1;
                    end else begin
                        gnt_dbg_s = 1'b1;
                    end
                end
                OWN_DBG: begin
                    if (burst_cnt_r < MAX_CNT) begin
                        gnt_dbg_s = 1'b1;
                    end else begin
                        gnt_cpu_s = 1'b1;
                    end
                end
                default: begin
                    // Tie from idle: the port that did not win last time goes first.
                    if (last_r == LAST_DBG) begin
                        gnt_cpu_s = 1'b1;
                    end else begin
                        gnt_dbg_s = 1'b1;
                    end
                end
            endcase
        end else begin
            gnt_cpu_s = 1'b0;
            gnt_dbg_s = 1'b0;
        end
    end

    // Next arbitration state: track the owner, its burst length and the last winner.
    always_comb begin
        owner_nx_s     = owner_r;
        last_nx_s      = last_r;
        burst_cnt_nx_s = burst_cnt_r;
        if (gnt_cpu_s) begin
            last_nx_s = LAST_CPU;
            if (owner_r == OWN_CPU) begin
                // The count saturates so that it never wraps back below MAX_BURST.
                if (burst_cnt_r < MAX_CNT) begin
                    burst_cnt_nx_s = burst_cnt_r + ONE_CNT;
                end else begin
                    burst_cnt_nx_s = burst_cnt_r;
                end
            end else begin
                owner_nx_s     = OWN_CPU;
                burst_cnt_nx_s = ONE_CNT;
            end
        end else if (gnt_dbg_s) begin
            last_nx_s = LAST_DBG;
            if (owner_r == OWN_DBG) begin
                if (burst_cnt_r < MAX_CNT) begin
                    burst_cnt_nx_s = burst_cnt_r + ONE_CNT;
                end else begin
                    burst_cnt_nx_s = burst_cnt_r;
                end
            end else begin
                owner_nx_s     = OWN_DBG;
                burst_cnt_nx_s = ONE_CNT;
            end
        end else begin
            owner_nx_s     = OWN_IDLE;
            burst_cnt_nx_s = {CW{1'b0}};
        end
    end

    // Arbitration state register. After reset last_owner is DBG, so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r     <= OWN_IDLE;
            last_r      <= LAST_DBG;
            burst_cnt_r <= {CW{1'b0}};
        end else begin
            owner_r     <= owner_nx_s;
            last_r      <= last_nx_s;
            burst_cnt_r <= burst_cnt_nx_s;
        end
    end

    // Memory mux: the granted port drives the memory. The bus is all zero when idle.
    always_comb begin
        mem_A  = {AW{1'b0}};
        mem_WD = {DW{1'b0}};
        mem_WE = 1'b0;
        if (gnt_cpu_s) begin
            mem_A  = cpu_addr;
            mem_WD = cpu_wdata;
            mem_WE = cpu_we;
        end else if (gnt_dbg_s) begin
            mem_A  = dbg_addr;
            mem_WD = dbg_wdata;
            mem_WE = dbg_we;
        end else begin
            mem_A  = {AW{1'b0}};
            mem_WD = {DW{1'b0}};
            mem_WE = 1'b0;
        end
    end

    // CPU read response. rdata holds its value until the port's next granted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid_r <= 1'b0;
            cpu_rdata_r  <= {DW{1'b0}};
        end else begin
            cpu_rvalid_r <= gnt_cpu_s & ~cpu_we;
            if (gnt_cpu_s && !cpu_we) begin
                cpu_rdata_r <= mem_RD;
            end
        end
    end

    // Debug read response. It has the same behaviour as the CPU response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_rvalid_r <= 1'b0;
            dbg_rdata_r  <= {DW{1'b0}};
        end else begin
            dbg_rvalid_r <= gnt_dbg_s & ~dbg_we;
            if (gnt_dbg_s && !dbg_we) begin
                dbg_rdata_r <= mem_RD;
            end
        end
    end

    assign cpu_gnt    = gnt_cpu_s;
    assign dbg_gnt    = gnt_dbg_s;
    assign cpu_rvalid = cpu_rvalid_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign dbg_rvalid = dbg_rvalid_r;
    assign dbg_rdata  = dbg_rdata_r;

    datamem_arbiter_chk #(
        .CW      (CW),
        .MAX_CNT (MAX_CNT)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .cpu_gnt   (gnt_cpu_s),
        .dbg_gnt   (gnt_dbg_s),
        .mem_WE    (mem_WE),
        .burst_cnt (burst_cnt_r)
    );

endmodule

// ============================================================================
// datamem_arbiter_chk
// ----------------------------------------------------------------------------
// Invariants of the arbiter: the two grants are mutually exclusive, the burst
// count never exceeds its limit, and a write needs a grant.
// Ports: clk, rst, both grants, mem_WE, and the burst count.
// ============================================================================
module datamem_arbiter_chk #(
    parameter int            CW      = 3,
    parameter logic [CW-1:0] MAX_CNT = '1
) (
    input logic          clk,
    input logic          rst,
    input logic          cpu_gnt,
    input logic          dbg_gnt,
    input logic          mem_WE,
    input logic [CW-1:0] burst_cnt
);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst)
        !(cpu_gnt && dbg_gnt));

    a_burst_bound: assert property (@(posedge clk) disable iff (!rst)
        burst_cnt <= MAX_CNT);

    a_we_needs_gnt: assert property (@(posedge clk) disable iff (!rst)
        mem_WE |-> (cpu_gnt || dbg_gnt));

endmodule

// File: tb/tb_datamem_arbiter.sv
module tb_datamem_arbiter;

    localparam logic [31:0] CWD = 32'hC0C0_0000;
    localparam logic [31:0] DWD = 32'hD0D0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    logic [31:0] mem [0:63];
    logic        ld_en = 1'b0;
    logic [5:0]  ld_idx = 6'd0;
    logic [31:0] ld_val = 32'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    datamem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    // Word-addressed memory model: combinational read, clocked write, preload port.
    assign mem_RD = mem[mem_A[7:2]];
    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        else if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
    end

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        dreq, dwe;
        logic [31:0] daddr, dwd;
        logic        egc, egd;
        logic        ecv;
        logic [31:0] ecd;
        logic        edv;
        logic [31:0] edd;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(
        input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
        input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
        input logic egc, input logic egd,
        input logic ecv, input logic [31:0] ecd, input logic edv, input logic [31:0] edd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.egc = egc; v.egd = egd; v.ecv = ecv; v.ecd = ecd; v.edv = edv; v.edd = edd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    endtask

    task automatic load(input logic [5:0] idx, input logic [31:0] val);
        ld_en = 1'b1; ld_idx = idx; ld_val = val;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] ea, ewd;
        logic        ewe, pc, pd, ec, ed;

        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        load(6'd4,  32'hDEAD_BEEF);
        load(6'd5,  32'h1111_1111);
        load(6'd6,  32'h2222_2222);
        load(6'd8,  32'h0000_0000);
        load(6'd9,  32'hAAAA_0001);
        load(6'd10, 32'hAAAA_0002);
        load(6'd12, 32'h5A5A_5A5A);

        // Reset state: grants are forced low even while both ports request.
        drive(1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b1, 32'h20, 32'h2);
        #1;
        chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_WE}, 32'd0);
        chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();
        rst = 1'b1;

        tbl[0]  = mk(1,0,32'h10,CWD, 0,0,32'h00,32'h0,        1,0, 0,32'h0,         0,32'h0);
        tbl[1]  = mk(0,0,32'h00,32'h0, 0,0,32'h00,32'h0,      0,0, 1,32'hDEADBEEF,  0,32'h0);
        tbl[2]  = mk(0,0,32'h00,32'h0, 1,1,32'h20,32'h12345678, 0,1, 0,32'hDEADBEEF, 0,32'h0);
        tbl[3]  = mk(1,0,32'h20,CWD, 0,0,32'h00,32'h0,        1,0, 0,32'hDEADBEEF,  0,32'h0);
        tbl[4]  = mk(0,0,32'h00,32'h0, 0,0,32'h00,32'h0,      0,0, 1,32'h12345678,  0,32'h0);
        tbl[5]  = mk(1,0,32'h14,CWD, 1,0,32'h24,DWD,          0,1, 0,32'h12345678,  0,32'h0);
        tbl[6]  = mk(1,0,32'h14,CWD, 1,0,32'h24,DWD,          0,1, 0,32'h12345678,  1,32'hAAAA0001);
        tbl[7]  = mk(1,0,32'h14,CWD, 1,0,32'h24,DWD,          0,1, 0,32'h12345678,  1,32'hAAAA0001);
        tbl[8]  = mk(1,0,32'h14,CWD, 1,0,32'h24,DWD,          0,1, 0,32'h12345678,  1,32'hAAAA0001);
        tbl[9]  = mk(1,0,32'h14,CWD, 1,0,32'h24,DWD,          1,0, 0,32'h12345678,  1,32'hAAAA0001);
        tbl[10] = mk(1,0,32'h14,CWD, 1,0,32'h24,DWD,          1,0, 1,32'h11111111,  0,32'hAAAA0001);
        tbl[11] = mk(0,0,32'h00,32'h0, 1,0,32'h28,DWD,        0,1, 1,32'h11111111,  0,32'hAAAA0001);
        tbl[12] = mk(1,0,32'h18,CWD, 1,0,32'h28,DWD,          0,1, 0,32'h11111111,  1,32'hAAAA0002);
        tbl[13] = mk(1,0,32'h18,CWD, 1,0,32'h28,DWD,          0,1, 0,32'h11111111,  1,32'hAAAA0002);
        tbl[14] = mk(1,0,32'h18,CWD, 1,0,32'h28,DWD,          0,1, 0,32'h11111111,  1,32'hAAAA0002);
        tbl[15] = mk(1,0,32'h18,CWD, 1,0,32'h28,DWD,          1,0, 0,32'h11111111,  1,32'hAAAA0002);
        tbl[16] = mk(0,0,32'h00,32'h0, 0,0,32'h00,32'h0,      0,0, 1,32'h22222222,  0,32'hAAAA0002);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd,
                  tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, tbl[i].dwd);
            ea  = tbl[i].egc ? tbl[i].caddr : (tbl[i].egd ? tbl[i].daddr : 32'd0);
            ewd = tbl[i].egc ? tbl[i].cwd   : (tbl[i].egd ? tbl[i].dwd   : 32'd0);
            ewe = (tbl[i].egc & tbl[i].cwe) | (tbl[i].egd & tbl[i].dwe);
            @(negedge clk);
            chk($sformatf("v%0d_cpu_gnt", i), {31'd0, cpu_gnt}, {31'd0, tbl[i].egc});
            chk($sformatf("v%0d_dbg_gnt", i), {31'd0, dbg_gnt}, {31'd0, tbl[i].egd});
            chk($sformatf("v%0d_mem_A", i), mem_A, ea);
            chk($sformatf("v%0d_mem_WD", i), mem_WD, ewd);
            chk($sformatf("v%0d_mem_WE", i), {31'd0, mem_WE}, {31'd0, ewe});
            chk($sformatf("v%0d_cpu_rvalid", i), {31'd0, cpu_rvalid}, {31'd0, tbl[i].ecv});
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tbl[i].ecd);
            chk($sformatf("v%0d_dbg_rvalid", i), {31'd0, dbg_rvalid}, {31'd0, tbl[i].edv});
            chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata, tbl[i].edd);
            next_cycle();
        end

        // Continuous contention from reset: CPU x4, DBG x4, CPU x4.
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h10, CWD, 1'b1, 1'b0, 32'h24, DWD);
        next_cycle();
        rst = 1'b1;
        pc = 1'b0; pd = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ec = (i < 4) || (i >= 8);
            ed = !ec;
            @(negedge clk);
            chk($sformatf("rr%0d_cpu_gnt", i), {31'd0, cpu_gnt}, {31'd0, ec});
            chk($sformatf("rr%0d_dbg_gnt", i), {31'd0, dbg_gnt}, {31'd0, ed});
            chk($sformatf("rr%0d_cpu_rvalid", i), {31'd0, cpu_rvalid}, {31'd0, pc});
            chk($sformatf("rr%0d_dbg_rvalid", i), {31'd0, dbg_rvalid}, {31'd0, pd});
            if (pc) chk($sformatf("rr%0d_cpu_rdata", i), cpu_rdata, 32'hDEADBEEF);
            if (pd) chk($sformatf("rr%0d_dbg_rdata", i), dbg_rdata, 32'hAAAA0001);
            pc = ec; pd = ed;
            next_cycle();
        end

        // A debug access, three idle cycles, then a tie: the CPU wins.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, DWD);
        @(negedge clk);
        chk("idle_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_no_gnt", i), {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
            next_cycle();
        end
        drive(1'b1, 1'b0, 32'h10, CWD, 1'b1, 1'b0, 32'h24, DWD);
        @(negedge clk);
        chk("tie_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        chk("tie_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        next_cycle();

        // Reset asserted between edges during a debug write, with a read response pending.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, DWD);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h30, 32'hBAD0BAD0);
        @(negedge clk);
        chk("mid_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("mid_mem_we", {31'd0, mem_WE}, 32'd1);
        chk("mid_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        chk("mid_dbg_rdata", dbg_rdata, 32'hAAAA0001);
        #1 rst = 1'b0;
        #1;
        chk("arst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("arst_mem_we", {31'd0, mem_WE}, 32'd0);
        chk("arst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        chk("arst_dbg_rdata", dbg_rdata, 32'd0);
        chk("arst_cpu_rdata", cpu_rdata, 32'd0);
        next_cycle();
        chk("arst_no_write", mem[12], 32'h5A5A5A5A);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h10, CWD, 1'b1, 1'b1, 32'h30, 32'hBAD0BAD0);
        @(negedge clk);
        chk("post_rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        chk("post_rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
